// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex-to-segment table for the seven-segment scan driver
package seg_pkg;
  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Active-high {g,f,e,d,c,b,a}, entry 15 first
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low seven-segment decoder
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  assign seg_n = ~HEX7_TABLE[nibble];
endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered 8-digit seven-segment scanner with anode blanking
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        pending
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   pend_data, act_data;
  logic [7:0]    pend_dp, act_dp;
  logic          slot_end, frame_bnd, in_blank;
  logic [3:0]    nibble;
  logic [6:0]    hex_seg, dig_seg;
  logic [7:0]    an_nxt;

  assign slot_end  = (presc == PW'(SCAN_DIV - 1));
  assign frame_bnd = slot_end && (idx == 3'd7);
  assign in_blank  = (presc < PW'(BLANK_CYC));
  assign nibble    = act_data[{idx, 2'b00} +: 4];
  assign an_nxt    = in_blank ? AN_OFF : ~(8'b1 << idx);

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg_n  (hex_seg)
  );

`ifdef SEG_LZB_EN
  logic [2:0] top_digit;

  // Highest nonzero nibble; digit 0 stays lit even for a zero value
  always_comb begin
    top_digit = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (act_data[i*4 +: 4] != 4'd0) top_digit = 3'(i);
    end
  end

  assign dig_seg = (idx > top_digit) ? SEG_BLANK : hex_seg;
`else
  assign dig_seg = hex_seg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= 3'd0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      an         <= AN_OFF;
      seg        <= 8'hFF;
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= idx + 3'd1;
      frame_done <= frame_bnd;

      // A load landing on the boundary bypasses the pending buffer
      if (frame_bnd && load) begin
        act_data <= data_in;
        act_dp   <= dp_in;
        pending  <= 1'b0;
      end else if (frame_bnd && pending) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        pending  <= 1'b0;
      end else if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pending   <= 1'b1;
      end

      an  <= an_nxt;
      seg <= {~act_dp[idx], dig_seg};
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed table-driven bench for seg_scan_driver
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [7:0]  an, seg;
  logic        frame_done, pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [63:0] segs;   // byte d = expected seg for digit d
  } vec_t;

  vec_t vec [5];

  seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Checks one 32-cycle frame starting right after a frame_done sample.
  // Optional loads are driven after step la / lb (-1 = none).
  task automatic check_frame(input string tag, input logic [63:0] segs,
                             input int la, input logic [31:0] va, input logic [7:0] da,
                             input int lb, input logic [31:0] vb, input logic [7:0] db);
    logic       ep;
    logic [7:0] ea;
    int         d, c;
    ep = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      d = (n - 1) / 4;
      c = (n - 1) % 4;
      if (n == 32) ep = 1'b0;
      else if (n - 1 == la || n - 1 == lb) ep = 1'b1;
      ea = 8'hFF;
      if (c != 0) ea = ~(8'h01 << d);
      chk({tag, " an"}, {24'd0, an}, {24'd0, ea});
      if (c != 0) chk({tag, " seg"}, {24'd0, seg}, {24'd0, segs[d*8 +: 8]});
      chk({tag, " frame_done"}, {31'd0, frame_done}, {31'd0, (n == 32)});
      chk({tag, " pending"}, {31'd0, pending}, {31'd0, ep});
      load = 1'b0;
      if (n == la) begin load = 1'b1; data_in = va; dp_in = da; end
      if (n == lb) begin load = 1'b1; data_in = vb; dp_in = db; end
    end
  endtask

  initial begin
`ifdef SEG_LZB_EN
    vec[0] = '{32'h01234567, 8'h00, 64'hFF_F9_A4_B0_99_92_82_F8};
    vec[3] = '{32'h00000C05, 8'h04, 64'hFF_FF_FF_FF_FF_46_C0_92};
    vec[4] = '{32'h00000000, 8'h00, 64'hFF_FF_FF_FF_FF_FF_FF_C0};
`else
    vec[0] = '{32'h01234567, 8'h00, 64'hC0_F9_A4_B0_99_92_82_F8};
    vec[3] = '{32'h00000C05, 8'h04, 64'hC0_C0_C0_C0_C0_46_C0_92};
    vec[4] = '{32'h00000000, 8'h00, 64'hC0_C0_C0_C0_C0_C0_C0_C0};
`endif
    vec[1] = '{32'h55555555, 8'h00, 64'h92_92_92_92_92_92_92_92};
    vec[2] = '{32'h89ABCDEF, 8'h81, 64'h00_90_88_83_C6_A1_86_0E};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset an", {24'd0, an}, 32'hFF);
    chk("reset seg", {24'd0, seg}, 32'hFF);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset pending", {31'd0, pending}, 32'd0);
    rst = 1'b0;

    // Load at cycle 5, pending until first boundary at cycle 32
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) chk("start an blank", {24'd0, an}, 32'hFF);
      if (k == 2) chk("start an digit0", {24'd0, an}, 32'hFE);
      if (k >= 5) begin
        chk("first frame pending", {31'd0, pending}, {31'd0, (k != 32)});
        chk("first frame_done", {31'd0, frame_done}, {31'd0, (k == 32)});
      end
      load = (k == 4);
      data_in = vec[0].value;
      dp_in = vec[0].dp;
    end
    check_frame("v0", vec[0].segs, -1, '0, '0, -1, '0, '0);

    // Tear-free: AAAAAAAA overwritten by 55555555 before the boundary
    check_frame("v0 hold", vec[0].segs, 8, 32'hAAAAAAAA, 8'h00, 20, vec[1].value, vec[1].dp);
    check_frame("v1", vec[1].segs, -1, '0, '0, -1, '0, '0);

    // Loads coincident with the frame boundary
    for (int i = 2; i <= 4; i++) begin
      check_frame("pre coincident", vec[i-1].segs, 31, vec[i].value, vec[i].dp, -1, '0, '0);
      check_frame("coincident", vec[i].segs, -1, '0, '0, -1, '0, '0);
    end

    // Reset mid-slot with digit 3 lit and data pending
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      load = (n == 2);
      data_in = vec[0].value;
      dp_in = vec[0].dp;
    end
    chk("pre-reset an", {24'd0, an}, 32'hF7);
    chk("pre-reset pending", {31'd0, pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async an", {24'd0, an}, 32'hFF);
    chk("async seg", {24'd0, seg}, 32'hFF);
    chk("async pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_frame("after reset", vec[4].segs, -1, '0, '0, -1, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
